// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body tracker.
package snake_pkg;

   localparam int unsigned DEF_COORD_W = 5;

   typedef struct packed {
      logic [DEF_COORD_W-1:0] x;
      logic [DEF_COORD_W-1:0] y;
   } point_t;

   function automatic int unsigned len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// Control/probe bundle between the step controller, renderer and the body tracker.
interface snake_body_tracker_if
   import snake_pkg::*;
#(
   parameter int unsigned COORD_W = DEF_COORD_W,
   parameter int unsigned MAX_LEN = 20
) ();

   localparam int unsigned LW = len_w(MAX_LEN);

   logic               clear;
   logic               move;
   logic [COORD_W-1:0] new_x;
   logic [COORD_W-1:0] new_y;
   logic               grow;
   logic [COORD_W-1:0] probe_x;
   logic [COORD_W-1:0] probe_y;
   logic [LW-1:0]      length;
   logic               full;
   logic               hit;
   logic               dead;
   logic               probe_hit;
   logic               probe_head;

   modport master (
      output clear, move, new_x, new_y, grow, probe_x, probe_y,
      input  length, full, hit, dead, probe_hit, probe_head
   );

   modport slave (
      input  clear, move, new_x, new_y, grow, probe_x, probe_y,
      output length, full, hit, dead, probe_hit, probe_head
   );

endinterface

// File: rtl/snake_seg_match.sv
// Combinational match of a query point against the live part of the segment array.
module snake_seg_match
   import snake_pkg::*;
#(
   parameter int unsigned COORD_W   = DEF_COORD_W,
   parameter int unsigned MAX_LEN   = 20,
   parameter bit          SKIP_HEAD = 1'b0
) (
   input  logic [2*COORD_W-1:0]        query,
   input  logic [2*COORD_W-1:0]        seg [MAX_LEN],
   input  logic [len_w(MAX_LEN)-1:0]   length,
   input  logic                        excl_tail,
   output logic                        match
);

   localparam int unsigned LW    = len_w(MAX_LEN);
   localparam int unsigned FIRST = SKIP_HEAD ? 32'd1 : 32'd0;

   // length is never 0, so dropping the tail cannot underflow
   logic [LW-1:0] live;
   assign live = length - LW'(excl_tail);

   always_comb begin
      match = 1'b0;
      for (int unsigned i = FIRST; i < MAX_LEN; i++) begin
         if ((LW'(i) < live) && (seg[i] == query)) begin
            match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snake_body_tracker.sv
// Head-first body shift store with self-collision and registered occupancy probe.
// Optional probe logic is built only when SNAKE_PROBE_EN is defined.
module snake_body_tracker
   import snake_pkg::*;
#(
   parameter int unsigned COORD_W = DEF_COORD_W,
   parameter int unsigned MAX_LEN = 20,
   parameter int unsigned START_X = 0,
   parameter int unsigned START_Y = 0
) (
   input logic                 clk,
   input logic                 rst_n,
   snake_body_tracker_if.slave bus
);

   localparam int unsigned   LW        = len_w(MAX_LEN);
   localparam int unsigned   PW        = 2 * COORD_W;
   localparam logic [PW-1:0] START_PT  = {COORD_W'(START_X), COORD_W'(START_Y)};
   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

   logic [PW-1:0] seg_q [MAX_LEN];
   logic [LW-1:0] len_q;
   logic          grow_pend_q;
   logic          dead_q;
   logic          hit_q;

   logic [PW-1:0] head_new;
   logic          full;
   logic          accept;
   logic          take;
   logic          collide;

   assign head_new = {bus.new_x, bus.new_y};
   assign full     = (len_q == MAX_LEN_L);
   assign accept   = bus.move & ~dead_q;
   assign take     = (grow_pend_q | bus.grow) & ~full;

   // Without growth the tail moves away this step, so it cannot be hit
   snake_seg_match #(
      .COORD_W   (COORD_W),
      .MAX_LEN   (MAX_LEN),
      .SKIP_HEAD (1'b0)
   ) u_collide (
      .query     (head_new),
      .seg       (seg_q),
      .length    (len_q),
      .excl_tail (~take),
      .match     (collide)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_q[i] <= '0;
         end
         seg_q[0]    <= START_PT;
         len_q       <= LW'(1);
         grow_pend_q <= 1'b0;
         dead_q      <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         hit_q <= 1'b0;
         if (accept) begin
            seg_q[0] <= head_new;
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
               seg_q[i] <= seg_q[i-1];
            end
            len_q       <= len_q + LW'(take);
            grow_pend_q <= take ? 1'b0 : (grow_pend_q | (bus.grow & ~full));
            if (collide) begin
               hit_q  <= 1'b1;
               dead_q <= 1'b1;
            end
         end else if (bus.grow && !full) begin
            grow_pend_q <= 1'b1;
         end
      end
   end

   assign bus.length = len_q;
   assign bus.full   = full;
   assign bus.hit    = hit_q;
   assign bus.dead   = dead_q;

`ifdef SNAKE_PROBE_EN
   logic [PW-1:0] probe_pt;
   logic          probe_body;
   logic          probe_hit_q;
   logic          probe_head_q;

   assign probe_pt = {bus.probe_x, bus.probe_y};

   snake_seg_match #(
      .COORD_W   (COORD_W),
      .MAX_LEN   (MAX_LEN),
      .SKIP_HEAD (1'b1)
   ) u_probe (
      .query     (probe_pt),
      .seg       (seg_q),
      .length    (len_q),
      .excl_tail (1'b0),
      .match     (probe_body)
   );

   // Samples the pre-edge body, so a same-cycle move is not reflected
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         probe_hit_q  <= 1'b0;
         probe_head_q <= 1'b0;
      end else begin
         probe_hit_q  <= probe_body;
         probe_head_q <= (probe_pt == seg_q[0]);
      end
   end

   assign bus.probe_hit  = probe_hit_q;
   assign bus.probe_head = probe_head_q;
`else
   logic unused_probe;
   assign unused_probe   = ^{bus.probe_x, bus.probe_y};
   assign bus.probe_hit  = 1'b0;
   assign bus.probe_head = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed table-driven bench for snake_body_tracker (two instances: MAX_LEN 8 and 4).
module tb_snake_body_tracker;
   import snake_pkg::*;

   localparam int unsigned LEN_A = 8;
   localparam int unsigned LEN_B = 4;
`ifdef SNAKE_PROBE_EN
   localparam bit PROBE = 1'b1;
`else
   localparam bit PROBE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_na;
   logic rst_nb;
   always #5 clk = ~clk;

   snake_body_tracker_if #(.COORD_W(5), .MAX_LEN(LEN_A)) ifa ();
   snake_body_tracker_if #(.COORD_W(5), .MAX_LEN(LEN_B)) ifb ();

   snake_body_tracker #(
      .COORD_W (5),
      .MAX_LEN (LEN_A),
      .START_X (3),
      .START_Y (4)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_na),
      .bus   (ifa.slave)
   );

   snake_body_tracker #(
      .COORD_W (5),
      .MAX_LEN (LEN_B),
      .START_X (0),
      .START_Y (0)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_nb),
      .bus   (ifb.slave)
   );

   typedef struct {
      logic   rst_n, clear, move, grow;
      point_t nw, pr;
      int     exp_len;
      logic   exp_hit, exp_dead, exp_ph, exp_pb, chk_seg;
      point_t s0, s1;
   } vec_t;

   vec_t vecs [20];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic point_t pt(input int x, input int y);
      point_t p;
      p.x = 5'(x);
      p.y = 5'(y);
      return p;
   endfunction

   function automatic vec_t mk(input int r, input int c, input int m, input int g,
                               input int nx, input int ny, input int px, input int py,
                               input int len, input int hit, input int dead,
                               input int ph, input int pb, input int chk,
                               input int s0x, input int s0y, input int s1x, input int s1y);
      vec_t v;
      v.rst_n = r[0]; v.clear = c[0]; v.move = m[0]; v.grow = g[0];
      v.nw = pt(nx, ny); v.pr = pt(px, py);
      v.exp_len = len; v.exp_hit = hit[0]; v.exp_dead = dead[0];
      v.exp_ph = ph[0]; v.exp_pb = pb[0]; v.chk_seg = chk[0];
      v.s0 = pt(s0x, s0y); v.s1 = pt(s1x, s1y);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst clr mv gr  nx ny  px py  len hit dead ph pb chk s0 s1
      vecs[0]  = mk(0, 0, 0, 0,  0,  0,  3,  4, 1, 0, 0, 0, 0, 1, 3, 4, 0, 0);
      vecs[1]  = mk(1, 0, 0, 0,  0,  0,  3,  4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 0, 0, 1,  0,  0,  3,  4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 0, 1, 0,  4,  4,  3,  4, 2, 0, 0, 1, 0, 1, 4, 4, 3, 4);
      vecs[4]  = mk(1, 0, 1, 0,  5,  4,  3,  4, 2, 0, 0, 0, 1, 1, 5, 4, 4, 4);
      vecs[5]  = mk(1, 0, 1, 0,  6,  4,  4,  4, 2, 0, 0, 0, 1, 1, 6, 4, 5, 4);
      vecs[6]  = mk(1, 0, 0, 0,  0,  0,  6,  4, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(1, 0, 0, 0,  0,  0,  4,  4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(1, 0, 1, 1,  6,  5,  0,  0, 3, 0, 0, 0, 0, 1, 6, 5, 6, 4);
      vecs[9]  = mk(1, 0, 1, 1,  5,  5,  0,  0, 4, 0, 0, 0, 0, 1, 5, 5, 6, 5);
      vecs[10] = mk(1, 0, 1, 0,  5,  4,  0,  0, 4, 0, 0, 0, 0, 1, 5, 4, 5, 5);
      vecs[11] = mk(1, 0, 1, 0,  6,  4,  0,  0, 4, 0, 0, 0, 0, 1, 6, 4, 5, 4);
      vecs[12] = mk(1, 0, 1, 1,  6,  5,  0,  0, 5, 1, 1, 0, 0, 1, 6, 5, 6, 4);
      vecs[13] = mk(1, 0, 0, 0,  0,  0,  0,  0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[14] = mk(1, 0, 1, 0, 10, 10,  6,  5, 5, 0, 1, 1, 1, 1, 6, 5, 6, 4);
      vecs[15] = mk(1, 0, 0, 0,  0,  0,  5,  5, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      vecs[16] = mk(1, 1, 0, 0,  0,  0,  6,  5, 1, 0, 0, 0, 0, 1, 3, 4, 0, 0);
      vecs[17] = mk(1, 0, 0, 1,  0,  0, 31, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[18] = mk(0, 0, 1, 1,  7,  7, 31, 31, 1, 0, 0, 0, 0, 1, 3, 4, 0, 0);
      vecs[19] = mk(1, 0, 1, 0,  4,  4, 31, 31, 1, 0, 0, 0, 0, 1, 4, 4, 3, 4);

      rst_nb = 1'b0;
      ifb.clear = 1'b0; ifb.move = 1'b0; ifb.grow = 1'b0;
      ifb.new_x = '0; ifb.new_y = '0; ifb.probe_x = '0; ifb.probe_y = '0;

      for (int i = 0; i < 20; i++) begin
         rst_na      = vecs[i].rst_n;
         ifa.clear   = vecs[i].clear;
         ifa.move    = vecs[i].move;
         ifa.grow    = vecs[i].grow;
         ifa.new_x   = vecs[i].nw.x;
         ifa.new_y   = vecs[i].nw.y;
         ifa.probe_x = vecs[i].pr.x;
         ifa.probe_y = vecs[i].pr.y;
         step();
         check($sformatf("a%0d_len", i), 32'(ifa.length), 32'(vecs[i].exp_len));
         check($sformatf("a%0d_full", i), 32'(ifa.full), 32'(vecs[i].exp_len == LEN_A));
         check($sformatf("a%0d_hit", i), 32'(ifa.hit), 32'(vecs[i].exp_hit));
         check($sformatf("a%0d_dead", i), 32'(ifa.dead), 32'(vecs[i].exp_dead));
         check($sformatf("a%0d_probe_head", i), 32'(ifa.probe_head),
               32'(vecs[i].exp_ph & PROBE));
         check($sformatf("a%0d_probe_hit", i), 32'(ifa.probe_hit),
               32'(vecs[i].exp_pb & PROBE));
         if (vecs[i].chk_seg) begin
            check($sformatf("a%0d_seg0", i), 32'(dut_a.seg_q[0]), 32'(vecs[i].s0));
            check($sformatf("a%0d_seg1", i), 32'(dut_a.seg_q[1]), 32'(vecs[i].s1));
         end
      end
      ifa.move = 1'b0; ifa.grow = 1'b0;

      // Saturation at MAX_LEN=4: grows past full are dropped
      step();
      check("b_reset_len", 32'(ifb.length), 32'd1);
      check("b_reset_full", 32'(ifb.full), 32'd0);
      rst_nb = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ifb.grow  = 1'b1;
         ifb.move  = 1'b1;
         ifb.new_x = 5'(k + 1);
         ifb.new_y = 5'd0;
         step();
         check($sformatf("b%0d_len", k), 32'(ifb.length), (k + 2 > 4) ? 32'd4 : 32'(k + 2));
         check($sformatf("b%0d_full", k), 32'(ifb.full), (k >= 2) ? 32'd1 : 32'd0);
         check($sformatf("b%0d_hit", k), 32'(ifb.hit), 32'd0);
         check($sformatf("b%0d_pend", k), 32'(dut_b.grow_pend_q), 32'd0);
      end
      ifb.move = 1'b0;
      ifb.grow = 1'b1;
      step();
      check("b_grow_full_pend", 32'(dut_b.grow_pend_q), 32'd0);
      check("b_grow_full_len", 32'(ifb.length), 32'd4);
      ifb.grow  = 1'b0;
      ifb.move  = 1'b1;
      ifb.new_x = 5'd7;
      step();
      check("b_after_move_pend", 32'(dut_b.grow_pend_q), 32'd0);
      check("b_after_move_len", 32'(ifb.length), 32'd4);
      check("b_after_move_full", 32'(ifb.full), 32'd1);
      check("b_after_move_dead", 32'(ifb.dead), 32'd0);
      check("b_after_move_seg0", 32'(dut_b.seg_q[0]), 32'(pt(7, 0)));
      ifb.move = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/snake_body_tracker.md
# snake_body_tracker

Sequential body store and collision engine for the snake game core. It holds up to MAX_LEN segment coordinates in a head-first shift array and advances the body on each move pulse, growing when a grow request is pending. It detects self-collision of the incoming head against the live body and answers registered cell-occupancy probes for the pixel renderer. It sits between the direction/step controller and the VGA draw logic, and replaces the fixed 20-entry combinational hit check.

## Interface
- COORD_W, 5, bit width of each x and y coordinate.
- MAX_LEN, 20, maximum number of segments, including the head.
- START_X, 0, head x loaded at reset and on clear.
- START_Y, 0, head y loaded at reset and on clear.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- clear  in  1  synchronous restart, with the same effect as reset.
- move  in  1  single-cycle step pulse; the body advances to new_x/new_y.
- new_x, new_y  in  COORD_W each  next head position, valid with move.
- grow  in  1  food-eaten pulse; sets the sticky grow_pend flag.
- probe_x, probe_y  in  COORD_W each  cell queried by the renderer.
- length  out  $clog2(MAX_LEN+1)  current segment count.
- full  out  1  length == MAX_LEN.
- hit  out  1  single-cycle self-collision pulse.
- dead  out  1  sticky; set on a collision and cleared only by reset or clear.
- probe_hit  out  1  the probe cell holds a body segment (not the head).
- probe_head  out  1  the probe cell is the head.

## Operation
- State:
  - seg[0..MAX_LEN-1] as {x,y} pairs; seg[0] is the head.
  - length.
  - grow_pend.
  - dead.
- Reset/clear:
  - seg[0] = (START_X, START_Y) and length = 1.
  - All other segments = 0.
  - grow_pend = 0, dead = 0, hit = 0, probe outputs = 0.
- Accepted move: move=1 and dead=0. A move while dead=1 is ignored, with no state change and no hit.
  - take = grow_pend | grow, gated by length < MAX_LEN.
  - Shift: seg[i] <= seg[i-1] for i = 1..MAX_LEN-1, and seg[0] <= (new_x, new_y).
  - length <= length + take.
  - grow_pend <= 0 if take; otherwise grow_pend <= grow_pend | grow.
- Collision is checked on the pre-move state:
  - Compare (new_x, new_y) against seg[i] for i < length.
  - Exclude seg[length-1] when take=0, because the tail vacates.
  - On any match: hit <= 1 and dead <= 1. The shift still happens, so the drawn head shows the crash.
- Grow without move: grow_pend <= 1.
- Grow at full: the request is dropped and grow_pend stays 0.
- Entries at index ≥ length are don't-care and never match.
- Coordinates are compared as unsigned COORD_W values. There is no wrap arithmetic inside the block; the step controller owns screen wrap.

## Timing
- Move accepted at edge t: seg, length, full, hit and dead are all valid after edge t+1.
- hit is high for exactly one cycle per colliding move.
- Probe: inputs sampled at edge t give probe_hit/probe_head valid after edge t+1 (1-cycle latency). The result reflects segment state as of edge t, before any same-cycle move.
- Priority, highest first: rst_n low, then clear, then move, then grow.
- Reset asserted mid-run overrides everything in that cycle. A pending grow is discarded.
- Back-to-back moves on consecutive cycles are supported with no bubbles.

## Configuration
- SNAKE_PROBE_EN defined:
  - Probe comparator array and registers are present.
  - probe_hit and probe_head behave as specified above.
- SNAKE_PROBE_EN undefined:
  - Probe logic is removed.
  - probe_hit and probe_head are tied to 0.
  - probe_x and probe_y are ignored.
  - The collision path is unchanged.

## Structure
- Package snake_pkg holds:
  - COORD_W default.
  - point_t typedef, a packed {x,y} struct.
  - Function len_w(MAX_LEN) for the length width.
- One sub-module, snake_seg_match:
  - Combinational comparator of a query point against the seg array.
  - Inputs: the seg array, length, and an exclude-tail flag.
  - Output: a match bit.
  - Instantiated once for collision and, under SNAKE_PROBE_EN, once for probe (index 1+ only).

## Test plan
- Reset with START=(3,4):
  - length=1, full=0, hit=0, dead=0.
  - Probe (3,4) gives probe_head=1 one cycle later.
- Grow then move ×3 to (4,4), (5,4), (6,4): length=2, with seg[0]=(6,4) and seg[1]=(5,4).
- Tail-chase, length 4 in a 2×2 square: moving onto the vacating tail gives hit=0. The same move with grow asserted gives hit=1, then dead=1 held.
- MAX_LEN=4: six grow+move pairs give length=4 and full=1. Later grows are dropped, and grow_pend reads 0 after the next move.
- dead=1, then move to a new cell: seg is unchanged and hit=0. Clear then restores length=1 and the head at START.
- Reset asserted in the same cycle as move+grow: post-reset state only, with length=1.
